plic_gateway: RTL

- Per-source interrupt gateway directly upstream of plic_core; converts raw external irq lines into the pending bits consumed by the core's priority/claim logic.
- Synchronises each source, applies level or edge trigger per the TM register, and holds each source's request until claimed.
- Blocks re-requests until completion, per RISC-V PLIC 1.0.0 gateway semantics.
- Source 0 is reserved and never pending.

---
 rtl/plic_define.sv | 21 ++
 rtl/dffer.sv | 29 ++
 rtl/dffr.sv | 27 ++
 rtl/plic_gateway_cell.sv | 154 +++++++++++++++
 rtl/plic_gateway.sv | 58 +++++
 5 files changed

// File: rtl/plic_define.sv
// -----------------------------------------------------------------------------
// plic_define
// Shared definitions for the PLIC interrupt gateway: default sizes, the
// per-source gateway state encoding and the trigger-mode encodings found in
// the TM register.
// -----------------------------------------------------------------------------
package plic_define;

    localparam int PLIC_IRQ_NUM      = 32;
    localparam int PLIC_GW_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        GW_IDLE = 2'b00,
        GW_PEND = 2'b01,
        GW_SERV = 2'b10
    } gw_state_e;

    localparam logic PLIC_TM_EDGE  = 1'b1;
    localparam logic PLIC_TM_LEVEL = 1'b0;

endpackage : plic_define

// File: rtl/dffer.sv
// -----------------------------------------------------------------------------
// dffer
// Register with load enable and asynchronous active-low reset to zero.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous reset, active-low
//   i_en     load enable; the register holds when low
//   i_d      next value
//   o_q      registered value
// -----------------------------------------------------------------------------
module dffer #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule : dffer

// File: rtl/dffr.sv
// -----------------------------------------------------------------------------
// dffr
// Register with asynchronous active-low reset to zero.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous reset, active-low
//   i_d      next value
//   o_q      registered value
// -----------------------------------------------------------------------------
module dffr #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_q <= '0;
        end else begin
            o_q <= i_d;
        end
    end

endmodule : dffr

// File: rtl/plic_gateway_cell.sv
// -----------------------------------------------------------------------------
// plic_gateway_cell
// One interrupt source of the PLIC gateway: input synchroniser, rising-edge
// detector, saturating pending-edge counter and IDLE/PEND/SERV state machine.
// Build option: PLIC_GATEWAY_SYNC_EN selects a 2-flop synchroniser; without it
// the line is sampled by a single flop (source already synchronous to i_clk).
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous reset, active-low
//   i_irq    raw interrupt line, active-high
//   i_tm     trigger mode (1 = rising edge, 0 = level-high)
//   i_claim  claim pulse from the core
//   i_comp   completion pulse from the core
//   o_ip     pending (state is PEND)
//   o_busy   claimed, awaiting completion (state is SERV)
// -----------------------------------------------------------------------------
module plic_gateway_cell
    import plic_define::*;
#(
    parameter int CNT_WIDTH = PLIC_GW_CNT_WIDTH
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_irq,
    input  logic i_tm,
    input  logic i_claim,
    input  logic i_comp,
    output logic o_ip,
    output logic o_busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 r_sync;
    logic                 r_prev;
    logic [1:0]           r_state;
    logic [CNT_WIDTH-1:0] r_cnt;

    gw_state_e            w_state;
    gw_state_e            w_state_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_cnt_en;
    logic                 w_edge;
    logic                 w_cnt_nz;
    logic                 w_edge_mode;

`ifdef PLIC_GATEWAY_SYNC_EN
    logic r_meta;

    dffr #(.W(1)) u_meta (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_irq),
        .o_q     (r_meta)
    );

    dffr #(.W(1)) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (r_meta),
        .o_q     (r_sync)
    );
`else
    dffr #(.W(1)) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_irq),
        .o_q     (r_sync)
    );
`endif

    dffr #(.W(1)) u_prev (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (r_sync),
        .o_q     (r_prev)
    );

    dffr #(.W(2)) u_state (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (w_state_nxt),
        .o_q     (r_state)
    );

    dffer #(.W(CNT_WIDTH)) u_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_cnt_en),
        .i_d     (w_cnt_nxt),
        .o_q     (r_cnt)
    );

    assign w_state     = gw_state_e'(r_state);
    assign w_edge      = r_sync & ~r_prev;
    assign w_cnt_nz    = (r_cnt != '0);
    assign w_edge_mode = (i_tm == PLIC_TM_EDGE);

    always_comb begin
        w_state_nxt = w_state;
        w_cnt_nxt   = r_cnt;
        w_cnt_en    = 1'b0;

        unique case (w_state)
            GW_IDLE: begin
                if (w_edge_mode) begin
                    if (w_edge || w_cnt_nz) begin
                        w_state_nxt = GW_PEND;
                    end
                    // A queued edge is consumed only when no fresh edge
                    // arrives; a fresh edge in the same cycle stands in for it.
                    if (w_cnt_nz && !w_edge) begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                        w_cnt_en  = 1'b1;
                    end
                end else if (r_sync) begin
                    w_state_nxt = GW_PEND;
                end
            end
            GW_PEND: begin
                if (i_claim) begin
                    w_state_nxt = GW_PEND == GW_PEND ? GW_SERV : GW_PEND;
                end
                if (w_edge_mode && w_edge && (r_cnt != CNT_MAX)) begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                    w_cnt_en  = 1'b1;
                end
            end
            GW_SERV: begin
                if (i_comp) begin
                    w_state_nxt = GW_IDLE;
                end
                if (w_edge_mode && w_edge && (r_cnt != CNT_MAX)) begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                    w_cnt_en  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = GW_IDLE;
            end
        endcase

        // Leaving edge mode discards any queued edges; the state is kept.
        if (i_tm == PLIC_TM_LEVEL) begin
            w_cnt_nxt = '0;
            w_cnt_en  = 1'b1;
        end
    end

    assign o_ip   = (w_state == GW_PEND);
    assign o_busy = (w_state == GW_SERV);

endmodule : plic_gateway_cell

// File: rtl/plic_gateway.sv
// -----------------------------------------------------------------------------
// plic_gateway
// Per-source interrupt gateway feeding plic_core. Converts raw interrupt lines
// into pending bits, holds each request until claimed and blocks re-requests
// until completion. Source 0 is reserved: its outputs are tied low and its
// inputs are ignored.
// Build option: PLIC_GATEWAY_SYNC_EN enables a 2-flop input synchroniser
// (irq-to-ip latency 3 edges); undefined, a single sampling flop is used
// (latency 2 edges).
// Ports:
//   clk_i    clock
//   rst_n_i  asynchronous reset, active-low
//   irq_i    raw interrupt lines, active-high
//   tm_i     trigger mode per source (1 = rising edge, 0 = level-high)
//   claim_i  one-hot single-cycle claim pulse from the core
//   comp_i   one-hot single-cycle completion pulse from the core
//   ip_o     pending bits to the core
//   busy_o   source claimed and awaiting completion
// -----------------------------------------------------------------------------
module plic_gateway
    import plic_define::*;
#(
    parameter int IRQ_NUM   = PLIC_IRQ_NUM,
    parameter int CNT_WIDTH = PLIC_GW_CNT_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [IRQ_NUM-1:0] irq_i,
    input  logic [IRQ_NUM-1:0] tm_i,
    input  logic [IRQ_NUM-1:0] claim_i,
    input  logic [IRQ_NUM-1:0] comp_i,
    output logic [IRQ_NUM-1:0] ip_o,
    output logic [IRQ_NUM-1:0] busy_o
);

    logic w_unused_src0;

    assign w_unused_src0 = ^{irq_i[0], tm_i[0], claim_i[0], comp_i[0]};

    assign ip_o[0]   = 1'b0;
    assign busy_o[0] = 1'b0;

    for (genvar gi = 1; gi < IRQ_NUM; gi++) begin : g_src
        plic_gateway_cell #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cell (
            .i_clk   (clk_i),
            .i_rst_n (rst_n_i),
            .i_irq   (irq_i[gi]),
            .i_tm    (tm_i[gi]),
            .i_claim (claim_i[gi]),
            .i_comp  (comp_i[gi]),
            .o_ip    (ip_o[gi]),
            .o_busy  (busy_o[gi])
        );
    end

endmodule : plic_gateway
